// File: rtl/spram_rd_streamer.sv
// Burst reader: streams len words from a 1-cycle-latency single-port RAM onto a valid/ready port
// through a 2-entry buffer. Define SPRAM_RD_STREAMER_LAST_EN to add the m_last output.
module spram_rd_streamer #(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [W_WORD-1:0] base_addr,
  input  logic [W_WORD:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [W_WORD-1:0] mem_addr,
  output logic [W_DATA-1:0] mem_din,
  input  logic [W_DATA-1:0] mem_dout,
  output logic              m_valid,
  output logic [W_DATA-1:0] m_data,
  input  logic              m_ready
`ifdef SPRAM_RD_STREAMER_LAST_EN
  ,
  output logic              m_last
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [W_WORD:0] ONE = (W_WORD+1)'(1);

  state_t            state;
  logic [W_WORD-1:0] addr;
  logic [W_WORD:0]   rd_left;
  logic [W_WORD:0]   wr_left;
  logic              pend;
  logic [1:0]        cnt;
  logic [W_DATA-1:0] buf0;
  logic [W_DATA-1:0] buf1;
  logic              pop;
  logic [2:0]        occ;

  assign pop = m_valid && m_ready;
  assign occ = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};

  // Issue is decided in the read cycle itself, crediting this cycle's pop,
  // so two entries are enough to sustain one word per cycle.
  assign mem_en   = (state == RUN) && (occ < 3'd2);
  assign mem_we   = 1'b0;
  assign mem_din  = '0;
  assign mem_addr = addr;
  assign m_valid  = (cnt != 2'd0);
  assign m_data   = buf0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
`ifdef SPRAM_RD_STREAMER_LAST_EN
  assign m_last   = m_valid && (wr_left == ONE);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      addr    <= '0;
      rd_left <= '0;
      wr_left <= '0;
      pend    <= 1'b0;
      cnt     <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      pend <= mem_en;
      if (mem_en) begin
        addr    <= addr + W_WORD'(1);
        rd_left <= rd_left - ONE;
      end
      if (pop) wr_left <= wr_left - ONE;

      // pend marks the cycle mem_dout carries the word read in the previous cycle
      unique case ({pend, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= mem_dout;
          else             buf1 <= mem_dout;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0 <= mem_dout;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_dout;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: if (start) begin
          addr    <= base_addr;
          rd_left <= len;
          wr_left <= len;
          state   <= (len == '0) ? DONE : RUN;
        end
        RUN:     if (mem_en && rd_left == ONE) state <= DRAIN;
        DRAIN:   if (pop && wr_left == ONE) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_rd_streamer.sv
// Randomized bench for spram_rd_streamer against a queue-based reference of the expected reads and words.
module tb_spram_rd_streamer;
  localparam int W_DATA = 32;
  localparam int W_WORD = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [W_WORD-1:0] base_addr = '0;
  logic [W_WORD:0]   len = '0;
  logic              busy, done, mem_en, mem_we;
  logic [W_WORD-1:0] mem_addr;
  logic [W_DATA-1:0] mem_din;
  logic [W_DATA-1:0] mem_dout;
  logic              m_valid;
  logic [W_DATA-1:0] m_data;
  logic              m_ready = 1'b1;
`ifdef SPRAM_RD_STREAMER_LAST_EN
  logic              m_last;
`endif

  logic [W_DATA-1:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int ready_idx = 0;
  logic [5:0] pat = 6'b101001;
  bit mon_en = 1'b0;

  logic [W_WORD-1:0] exp_addr_q[$];
  logic [W_DATA-1:0] exp_data_q[$];
  int iss_total, iss_d1, iss_d2, npop, mon_occ;
  logic prev_stall;
  logic [W_DATA-1:0] prev_data;

  always #5 clk = ~clk;

  spram_rd_streamer #(.W_DATA(W_DATA), .W_WORD(W_WORD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .m_valid(m_valid), .m_data(m_data),
`ifdef SPRAM_RD_STREAMER_LAST_EN
    .m_last(m_last),
`endif
    .m_ready(m_ready)
  );

  always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       begin m_ready = pat[ready_idx % 6]; ready_idx++; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: read addresses, word order, backpressure stability and buffer occupancy.
  always @(negedge clk) begin
    if (!rstn || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      mon_occ = iss_d2 - npop;
      check_eq("occupancy_le2", mon_occ <= 2, 1);
      check_eq("valid_vs_model", m_valid, mon_occ != 0);
      check_eq("we_din_zero", {mem_we, mem_din}, 0);
      if (prev_stall) begin
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_data", m_data, prev_data);
      end
      if (mem_en) begin
        check_eq("read_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check_eq("rd_addr", mem_addr, exp_addr_q.pop_front());
        iss_total++;
      end
      if (m_valid && m_ready) begin
        check_eq("word_expected", exp_data_q.size() != 0, 1);
        if (exp_data_q.size() != 0) begin
          check_eq("m_data", m_data, exp_data_q.pop_front());
`ifdef SPRAM_RD_STREAMER_LAST_EN
          check_eq("m_last", m_last, exp_data_q.size() == 0);
`endif
        end
        npop++;
      end
`ifdef SPRAM_RD_STREAMER_LAST_EN
      else if (m_valid) check_eq("m_last_stall", m_last, exp_data_q.size() == 1);
`endif
      iss_d2 = iss_d1;
      iss_d1 = iss_total;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic clear_model();
    exp_addr_q.delete();
    exp_data_q.delete();
    iss_total = 0; iss_d1 = 0; iss_d2 = 0; npop = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_mem_en"}, mem_en, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_m_valid"}, m_valid, 0);
    check_eq({tag, "_m_data"}, m_data, 0);
`ifdef SPRAM_RD_STREAMER_LAST_EN
    check_eq({tag, "_m_last"}, m_last, 0);
`endif
  endtask

  // Called at posedge+1; start is accepted at the next rising edge.
  task automatic run_burst(input logic [W_WORD-1:0] b, input int n, input int mode,
                           input bit poke, input bit abort);
    int first_v, done_k, pops;
    clear_model();
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(W_WORD'((int'(b) + i) % DEPTH));
      exp_data_q.push_back(W_DATA'((int'(b) + i) % DEPTH + 100));
    end
    ready_mode = mode;
    ready_idx  = 0;
    start = 1'b1; base_addr = b; len = (W_WORD+1)'(n);
    @(posedge clk); #1;
    start = 1'b0; base_addr = W_WORD'($urandom); len = (W_WORD+1)'($urandom);
    first_v = -1; done_k = -1; pops = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("busy_after_accept", busy, 1);
      if (m_valid && first_v < 0) first_v = k;
      if (abort && pops == 2 && m_valid) begin
        #2 rstn = 1'b0;
        #1 check_outputs_zero("abort");
        return;
      end
      if (m_valid && m_ready) pops++;
      if (poke && k == 3) begin start = 1'b1; base_addr = 4'h9; len = 5'd5; end
      if (poke && k == 4) start = 1'b0;
      if (done) begin
        done_k = k;
        check_eq("busy_in_done", busy, 1);
        break;
      end
    end
    check_eq("done_seen", done_k >= 0, 1);
    if (n > 0) check_eq("first_valid_lat", first_v, 2);
    else       check_eq("len0_no_valid", first_v, -1);
    if (mode == 0) check_eq("done_lat", done_k, (n == 0) ? 0 : n + 2);
    @(negedge clk);
    check_eq("done_one_pulse", done, 0);
    check_eq("idle_after_done", busy, 0);
    check_eq("reads_left", exp_addr_q.size(), 0);
    check_eq("words_left", exp_data_q.size(), 0);
  endtask

  initial begin
    bit activity;
    for (int i = 0; i < DEPTH; i++) mem[i] = W_DATA'(i + 100);
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    check_eq("reset_we_din", {mem_we, mem_din}, 0);
    clear_model();
    rstn = 1'b1;
    mon_en = 1'b1;
    run_burst(4'h2, 4, 0, 1'b0, 1'b0);
    @(posedge clk); #1 run_burst(4'hE, 4, 0, 1'b0, 1'b0);
    @(posedge clk); #1 run_burst(4'h5, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1 run_burst(4'h3, 6, 1, 1'b0, 1'b0);
    @(posedge clk); #1 run_burst(W_WORD'($urandom), 16, 0, 1'b0, 1'b0);
    @(posedge clk); #1 run_burst(W_WORD'($urandom), 3, 0, 1'b1, 1'b0);
    @(posedge clk); #1 run_burst(W_WORD'($urandom), 16, 2, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      run_burst(W_WORD'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
                int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    @(posedge clk); #1 run_burst(4'h0, 8, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    clear_model();
    #1 rstn = 1'b1;
    activity = 1'b0;
    repeat (8) begin
      @(negedge clk);
      activity = activity | mem_en | m_valid;
    end
    check_eq("quiet_after_reset", activity, 0);
    @(posedge clk); #1 run_burst(4'h0, 2, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
